ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, requester byte-address width.
REQ-003 SHALL have parameter RAM_AW, default 12, RAM word-address width; RAM address = req addr[ADDR_W-1:ADDR_W-RAM_AW].
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_req, m1_req  in  1 each  access request; m0 = CPU data port, m1 = I/O/DMA master.
REQ-007 SHALL have ports m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-008 SHALL have ports m0_addr, m1_addr  in  ADDR_W each  byte address.
REQ-009 SHALL have ports m0_wdata, m1_wdata  in  DATA_W each  write data.
REQ-010 SHALL have ports m0_gnt, m1_gnt  out  1 each  request accepted this cycle.
REQ-011 SHALL have ports m0_rsp, m1_rsp  out  1 each  one-cycle completion pulse (read data valid / write done).
REQ-012 SHALL have port rdata  out  DATA_W  read data, valid while mX_rsp high.
REQ-013 SHALL have ports ram_addr  out  RAM_AW, ram_wdata  out  DATA_W, ram_we  out  1  drive RAM port A.
REQ-014 SHALL have port ram_rdata  in  DATA_W  RAM port A output, registered in RAM (1-cycle read latency).

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE/ISSUE.
REQ-016 SHALL, in IDLE or RESP, accept at most one request per cycle: assert that master's gnt combinationally, latch we/addr/wdata/owner, go to ISSUE.
REQ-017 SHALL, in IDLE or RESP with no request, go to (stay in) IDLE.
REQ-018 SHALL, in ISSUE, drive ram_addr/ram_wdata from latched values and ram_we = latched we for exactly that cycle, then go to RESP.
REQ-019 SHALL, in RESP, pulse owner's mX_rsp and present rdata = ram_rdata; latency accept-edge to rsp = 2 cycles; back-to-back throughput one access per 2 cycles.
REQ-020 SHALL hold ram_we = 0 in every state except ISSUE; ram_addr/ram_wdata hold last value outside ISSUE.
REQ-021 SHALL never assert m0_gnt and m1_gnt together, nor gnt outside IDLE/RESP.
REQ-022 SHALL, on simultaneous m0_req and m1_req, resolve per REQ-027/028.
REQ-023 SHALL treat requester req as level; a master keeps req/we/addr/wdata stable until gnt; deassertion before gnt withdraws the request with no side effect.
REQ-024 SHALL produce rdata = ram_rdata also for writes (don't-care to requester).

Reset
REQ-025 SHALL, on reset low, asynchronously force state IDLE, all gnt/rsp 0, ram_we 0, ram_addr 0, ram_wdata 0, last-owner = m1 (so m0 wins first tie).
REQ-026 SHALL, on reset mid-transaction, abandon it with no rsp pulse; a write already in ISSUE on that edge completes in RAM only if reset rose after that edge.

Configuration
REQ-027 SHALL, with ARB_ROUND_ROBIN_EN defined, grant a tie to the master not granted most recently (last-owner updated on every grant).
REQ-028 SHALL, without ARB_ROUND_ROBIN_EN, grant a tie always to m0 (fixed priority); last-owner register absent.

Structure
REQ-029 SHALL place state enum (IDLE, ISSUE, RESP) and default width constants in shared package mem_pkg.
REQ-030 SHALL be single module; no sub-module (RAM and CPU remain external).

Verification
REQ-031 m0 read addr 0x0120, RAM word 0x12 = 0xBEEF -> m0_gnt cycle 0, ram_addr 0x012 ram_we 0 cycle 1, m0_rsp with rdata 0xBEEF cycle 2.
REQ-032 m1 write 0xA5A5 to 0x0F00 then m1 read 0x0F00 held -> ram_we 1 one cycle, second gnt in RESP cycle, read returns 0xA5A5.
REQ-033 m0 and m1 both requesting continuously, RR build -> grants alternate m0,m1,m0,m1; fixed build -> m0 only, m1 starved.
REQ-034 reset low during ISSUE of m0 read -> no m0_rsp, outputs at reset values, next request after release served normally with 2-cycle latency.
REQ-035 m1_req pulsed one cycle while m0 owns ISSUE -> m1 never granted, no m1_rsp, ram_we never 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the RAM port arbiter.
package mem_pkg;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefAddrW = 16;
   localparam int unsigned DefRamAw = 12;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StResp  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OwnerM0 = 1'b0,
      OwnerM1 = 1'b1
   } owner_e;

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for a single synchronous RAM port: accept, issue, respond.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed m0 priority.
module ram_port_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned RAM_AW = DefRamAw
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_we,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_rsp,
   output logic              m1_rsp,
   output logic [DATA_W-1:0] rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              accept_win;
   logic              pick_m1;
   logic              unused_addr;

   // Byte-offset bits below the RAM word address are not needed.
   assign unused_addr = ^{m0_addr[ADDR_W-RAM_AW-1:0], m1_addr[ADDR_W-RAM_AW-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
   owner_e last_q, last_d;

   // On a tie, m1 wins only if m0 was the most recent grantee.
   assign pick_m1 = m1_req & (~m0_req | (last_q == OwnerM0));

   always_comb begin
      last_d = last_q;
      if (accept_win && (m0_req || m1_req)) begin
         last_d = owner_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= OwnerM1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign pick_m1 = m1_req & ~m0_req;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      accept_win  = 1'b0;
      unique case (state_q)
         StIdle, StResp: begin
            accept_win = 1'b1;
            if (m0_req || m1_req) begin
               state_d     = StIssue;
               owner_d     = pick_m1 ? OwnerM1 : OwnerM0;
               we_d        = pick_m1 ? m1_we : m0_we;
               ram_addr_d  = pick_m1 ? m1_addr[ADDR_W-1 -: RAM_AW]
                                     : m0_addr[ADDR_W-1 -: RAM_AW];
               ram_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
            end else begin
               state_d = StIdle;
            end
         end
         StIssue: state_d = StResp;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         owner_q     <= OwnerM1;
         we_q        <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   // Grants are combinational, so they are also masked directly by reset.
   assign m0_gnt    = reset & accept_win & m0_req & ~pick_m1;
   assign m1_gnt    = reset & accept_win & pick_m1;
   assign m0_rsp    = (state_q == StResp) & (owner_q == OwnerM0);
   assign m1_rsp    = (state_q == StResp) & (owner_q == OwnerM1);
   assign ram_we    = (state_q == StIssue) & we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign rdata     = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: transaction-level model plus directed literal checks.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
   logic [15:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
   logic        m0_gnt, m1_gnt, m0_rsp, m1_rsp, ram_we;
   logic [15:0] rdata, ram_wdata;
   logic [11:0] ram_addr;
   logic [15:0] ram_rdata = '0;

   logic [15:0] mem [4096];
   logic [15:0] exp_mem [4096];

   int n_cmp = 0;
   int n_bad = 0;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   ram_port_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m1_req    (m1_req),
      .m0_we     (m0_we),
      .m1_we     (m1_we),
      .m0_addr   (m0_addr),
      .m1_addr   (m1_addr),
      .m0_wdata  (m0_wdata),
      .m1_wdata  (m1_wdata),
      .m0_gnt    (m0_gnt),
      .m1_gnt    (m1_gnt),
      .m0_rsp    (m0_rsp),
      .m1_rsp    (m1_rsp),
      .rdata     (rdata),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // External synchronous RAM, read-first, one-cycle read latency.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: one outstanding access, issued 1 cycle and answered 2 cycles after accept.
   logic        p_v = 1'b0;
   int          p_age = 0;
   logic        p_m1, p_we;
   logic [11:0] p_addr;
   logic [15:0] p_wdata, p_rd;
   logic        last_m1 = 1'b1;
   logic [11:0] e_addr = '0;
   logic [15:0] e_wdata = '0;
   logic        e_g0, e_g1, e_r0, e_r1, e_we, open, pick1;

   always @(negedge clk) begin
      if (!reset) begin
         p_v = 1'b0;
         last_m1 = 1'b1;
         e_addr = '0;
         e_wdata = '0;
         chk("rst_gnt0", m0_gnt, 0);
         chk("rst_gnt1", m1_gnt, 0);
         chk("rst_rsp0", m0_rsp, 0);
         chk("rst_rsp1", m1_rsp, 0);
         chk("rst_we", ram_we, 0);
         chk("rst_addr", ram_addr, 0);
         chk("rst_wdata", ram_wdata, 0);
      end else begin
         {e_g0, e_g1, e_r0, e_r1, e_we} = '0;
         if (p_v) p_age++;
         open = !p_v || p_age == 2;
         if (p_v && p_age == 1) begin
            e_addr = p_addr;
            e_wdata = p_wdata;
            e_we = p_we;
            if (p_we) exp_mem[p_addr] = p_wdata;
            else p_rd = exp_mem[p_addr];
         end
         if (p_v && p_age == 2) begin
            if (p_m1) e_r1 = 1'b1;
            else e_r0 = 1'b1;
            if (!p_we) chk("rdata", rdata, p_rd);
         end
         pick1 = 1'b0;
         if (open && (m0_req || m1_req)) begin
            pick1 = m1_req && (!m0_req || (RrEn && !last_m1));
            e_g1 = pick1;
            e_g0 = !pick1;
         end
         chk("gnt0", m0_gnt, e_g0);
         chk("gnt1", m1_gnt, e_g1);
         chk("rsp0", m0_rsp, e_r0);
         chk("rsp1", m1_rsp, e_r1);
         chk("ram_we", ram_we, e_we);
         chk("ram_addr", ram_addr, e_addr);
         chk("ram_wdata", ram_wdata, e_wdata);
         if (e_g0 || e_g1) begin
            p_v = 1'b1;
            p_age = 0;
            p_m1 = pick1;
            p_we = pick1 ? m1_we : m0_we;
            p_addr = pick1 ? m1_addr[15:4] : m0_addr[15:4];
            p_wdata = pick1 ? m1_wdata : m0_wdata;
            last_m1 = pick1;
         end else if (p_v && p_age == 2) begin
            p_v = 1'b0;
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_all();
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   int g0_cnt, g1_cnt;
   logic seen_m1, seen_we;

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 16'h1000 ^ 16'(i);
         exp_mem[i] = 16'h1000 ^ 16'(i);
      end
      mem[12'h012] = 16'hBEEF;
      exp_mem[12'h012] = 16'hBEEF;

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      nxt();
      nxt();

      // m0 read of 0x0120
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0120;
      mid(); chk("t1_gnt", m0_gnt, 1);
      nxt(); idle_all();
      mid(); chk("t1_addr", ram_addr, 12'h012); chk("t1_we", ram_we, 0);
      nxt();
      mid(); chk("t1_rsp", m0_rsp, 1); chk("t1_rdata", rdata, 16'hBEEF);

      // m1 write then held read of the same address
      nxt();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0F00; m1_wdata = 16'hA5A5;
      mid(); chk("t2_gnt_wr", m1_gnt, 1);
      nxt(); m1_we = 1'b0;
      mid(); chk("t2_we", ram_we, 1); chk("t2_addr", ram_addr, 12'h0F0);
      nxt();
      mid(); chk("t2_rsp_wr", m1_rsp, 1); chk("t2_gnt_rd", m1_gnt, 1);
      nxt(); idle_all();
      mid(); chk("t2_we_rd", ram_we, 0);
      nxt();
      mid(); chk("t2_rsp_rd", m1_rsp, 1); chk("t2_rdata", rdata, 16'hA5A5);

      // Both masters requesting continuously
      nxt();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0400;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0500;
      g0_cnt = 0; g1_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         mid();
         if (m0_gnt) g0_cnt++;
         if (m1_gnt) g1_cnt++;
         nxt();
      end
      idle_all();
`ifdef ARB_ROUND_ROBIN_EN
      chk("t3_g0_cnt", g0_cnt, 4);
      chk("t3_g1_cnt", g1_cnt, 4);
`else
      chk("t3_g0_cnt", g0_cnt, 8);
      chk("t3_g1_cnt", g1_cnt, 0);
`endif
      nxt();
      nxt();

      // Reset during the ISSUE cycle of an m0 read
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0120;
      mid(); chk("t4_gnt", m0_gnt, 1);
      nxt(); reset = 1'b0; idle_all();
      mid(); chk("t4_rsp", m0_rsp, 0); chk("t4_addr", ram_addr, 0); chk("t4_we", ram_we, 0);
      nxt();
      mid(); chk("t4_rsp_after", m0_rsp, 0);
      nxt(); reset = 1'b1;
      nxt();
      m0_req = 1'b1;
      mid(); chk("t4_gnt2", m0_gnt, 1);
      nxt(); idle_all();
      mid(); chk("t4_rsp_early", m0_rsp, 0);
      nxt();
      mid(); chk("t4_rsp2", m0_rsp, 1); chk("t4_rdata2", rdata, 16'hBEEF);

      // m1 pulses a write request while m0 owns ISSUE
      nxt();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0300;
      mid();
      nxt(); m0_req = 1'b0;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0700; m1_wdata = 16'h1234;
      seen_m1 = 1'b0; seen_we = 1'b0;
      mid(); seen_m1 = seen_m1 | m1_gnt | m1_rsp; seen_we = seen_we | ram_we;
      nxt(); idle_all();
      for (int i = 0; i < 4; i++) begin
         mid();
         seen_m1 = seen_m1 | m1_gnt | m1_rsp;
         seen_we = seen_we | ram_we;
         nxt();
      end
      chk("t5_m1_seen", seen_m1, 0);
      chk("t5_we_seen", seen_we, 0);
      chk("t5_mem", mem[12'h070], 16'h1000 ^ 16'h0070);

      repeat (3) nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
